// File: rtl/axis_conv_pkg.sv
// Shared helpers for the AXI4-Stream width converters: ratio and lane-index
// width derivation, the trailing-lane priority encoder and the packet FSM encoding.
package axis_conv_pkg;

    // Widest strobe vector last_lane() can scan (1024-bit slave bus).
    localparam int MAX_STRB = 128;

    typedef enum logic {
        SOP  = 1'b0,
        BODY = 1'b1
    } pkt_state_t;

    function automatic int calc_ratio(input int s_w, input int m_w);
        return s_w / m_w;
    endfunction

    // Lane counter width; never narrower than one bit, even for ratio 1.
    function automatic int calc_lane_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // Last lane to emit from a word. Non-last words emit every lane. Last
    // words stop at the highest lane that has any strobe bit set, or at lane 0
    // when no strobe bit is set.
    function automatic int last_lane(input logic [MAX_STRB-1:0] strb, input logic tlast,
                                     input int ratio, input int lane_bytes);
        int hi = 0;
        if (!tlast) return ratio - 1;
        for (int b = 0; b < MAX_STRB; b++)
            if (b < ratio * lane_bytes && strb[b]) hi = b / lane_bytes;
        return hi;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible on
// dout while empty is low. A write is ignored when full and a read is ignored
// when empty.
module axis_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wptr, rptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign full  = (count == (DEPTH_BITS+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // Storage array; it holds no control state, so it has no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_downsizer.sv
// AXI4-Stream width down-converter. Wide words are queued in a FWFT FIFO and
// sent out as narrow beats, least-significant lane first. On the last word of
// a packet, lanes above the highest strobed lane are trimmed. By default tuser
// appears only on the first beat of a packet. Define
// AXIS_DOWNSIZER_TUSER_ALL_BEATS_EN to repeat the head word's tuser on every
// beat of that word.
module axis_downsizer #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int C_M_AXIS_DATA_WIDTH = 64,
    parameter int C_TUSER_WIDTH       = 128,
    parameter int C_FIFO_DEPTH_BITS   = 4
) (
    input  logic                             axi_aclk,
    input  logic                             axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]         s_axis_tuser,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]         m_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast
);
    import axis_conv_pkg::*;

    localparam int S      = C_S_AXIS_DATA_WIDTH;
    localparam int M      = C_M_AXIS_DATA_WIDTH;
    localparam int SB     = S / 8;
    localparam int MB     = M / 8;
    localparam int TU     = C_TUSER_WIDTH;
    localparam int RATIO  = calc_ratio(S, M);
    localparam int LANE_W = calc_lane_w(RATIO);
    localparam int FW     = S + SB + TU + 1;

    logic                ready_en;
    logic                fifo_full, fifo_empty, fifo_wr, fifo_pop;
    logic [FW-1:0]       fifo_din, fifo_dout;
    logic [S-1:0]        head_data;
    logic [SB-1:0]       head_strb;
    logic [TU-1:0]       head_user;
    logic                head_last;
    logic [MAX_STRB-1:0] strb_ext;
    logic [LANE_W-1:0]   head_last_lane;
    logic [LANE_W-1:0]   lane;
    logic                lane_at_end, beat_last, out_free, load;
    logic [TU-1:0]       beat_user;
    pkt_state_t          state;

    assign s_axis_tready = ready_en && !fifo_full;
    assign fifo_wr       = s_axis_tvalid && s_axis_tready;
    assign fifo_din      = {s_axis_tuser, s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    assign {head_user, head_last, head_strb, head_data} = fifo_dout;

    axis_sync_fifo #(
        .WIDTH      (FW),
        .DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk   (axi_aclk),
        .rst_n (axi_resetn),
        .wr_en (fifo_wr),
        .din   (fifo_din),
        .rd_en (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Index of the final lane to emit from the current head word.
    always_comb begin
        strb_ext           = '0;
        strb_ext[SB-1:0]   = head_strb;
        head_last_lane     = LANE_W'(last_lane(strb_ext, head_last, RATIO, MB));
    end

    assign lane_at_end = (lane == head_last_lane);
    assign beat_last   = head_last && lane_at_end;
    assign out_free    = !m_axis_tvalid || m_axis_tready;
    assign load        = out_free && !fifo_empty;
    assign fifo_pop    = load && lane_at_end;

`ifdef AXIS_DOWNSIZER_TUSER_ALL_BEATS_EN
    assign beat_user = head_user;
`else
    assign beat_user = (state == SOP) ? head_user : '0;
`endif

    // Input ready stays off until the first edge after reset is released.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) ready_en <= 1'b0;
        else             ready_en <= 1'b1;
    end

    // Output register, lane walker and packet FSM. All three advance together on each load.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state         <= SOP;
            lane          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
        end else if (out_free) begin
            if (!fifo_empty) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= head_data[lane*M +: M];
                m_axis_tstrb  <= head_strb[lane*MB +: MB];
                m_axis_tuser  <= beat_user;
                m_axis_tlast  <= beat_last;
                lane          <= lane_at_end ? '0 : lane + LANE_W'(1);
                case (state)
                    SOP:     if (!beat_last) state <= BODY;
                    BODY:    if (beat_last)  state <= SOP;
                    default: state <= SOP;
                endcase
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer at the default 256->64 configuration.
module tb_axis_downsizer;
    localparam int S  = 256;
    localparam int M  = 64;
    localparam int SB = S / 8;
    localparam int MB = M / 8;
    localparam int TU = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [S-1:0]  s_tdata = '0;
    logic [SB-1:0] s_tstrb = '0;
    logic [TU-1:0] s_tuser = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [M-1:0]  m_tdata;
    logic [MB-1:0] m_tstrb;
    logic [TU-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int acc_cyc = 0;
    int push_timeouts = 0;
    int got = 0;

    logic [M-1:0]  cap_data [100];
    logic [MB-1:0] cap_strb [100];
    logic [TU-1:0] cap_user [100];
    logic          cap_last [100];
    int            cap_cyc  [100];

    axis_downsizer dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Lane k of word w: tag byte A5, word id, lane index.
    function automatic logic [M-1:0] mk_lane(input int w, input int k);
        logic [7:0] wb, kb;
        wb = w[7:0];
        kb = k[7:0];
        return {8'hA5, 40'h0, wb, kb};
    endfunction

    function automatic logic [S-1:0] mk_word(input int w);
        logic [S-1:0] r;
        for (int k = 0; k < 4; k++) r[k*M +: M] = mk_lane(w, k);
        return r;
    endfunction

    task automatic push(input int w, input logic [SB-1:0] st, input logic [TU-1:0] u, input logic l);
        bit ok = 0;
        s_tdata = mk_word(w); s_tstrb = st; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk); #1;
                ok = 1;
                acc_cyc = cyc_cnt;
            end
        end
        s_tvalid = 1'b0;
        if (!ok) push_timeouts++;
    endtask

    task automatic collect(input int n, input int budget, input int pct);
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            m_tready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (m_tvalid && m_tready) begin
                cap_data[got] = m_tdata; cap_strb[got] = m_tstrb; cap_user[got] = m_tuser;
                cap_last[got] = m_tlast; cap_cyc[got] = cyc_cnt;
                got++;
            end
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
        checks++; if (m_tstrb !== '0) begin errors++; $display("FAIL reset_tstrb got=%h exp=0", m_tstrb); end
        checks++; if (m_tuser !== '0) begin errors++; $display("FAIL reset_tuser got=%h exp=0", m_tuser); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL release_tready_pre_edge got=%b exp=0", s_tready); end
        @(posedge clk); #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b exp=1", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL release_tvalid got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_full_word;
        logic [TU-1:0] eu;
        @(posedge clk); #1;
        fork
            push(1, '1, 128'hAB, 1'b1);
            collect(4, 40, 100);
        join
        checks++; if (got !== 4) begin errors++; $display("FAIL full_count got=%0d exp=4", got); end
        checks++; if (cap_cyc[0] !== acc_cyc + 1) begin errors++; $display("FAIL full_latency got=%0d exp=%0d", cap_cyc[0], acc_cyc + 1); end
        for (int k = 0; k < 4; k++) begin
            eu = (k == 0) ? 128'hAB : '0;
            checks++; if (cap_data[k] !== mk_lane(1, k)) begin errors++; $display("FAIL full_data%0d got=%h exp=%h", k, cap_data[k], mk_lane(1, k)); end
            checks++; if (cap_strb[k] !== 8'hFF) begin errors++; $display("FAIL full_strb%0d got=%h exp=ff", k, cap_strb[k]); end
            checks++; if (cap_user[k] !== eu) begin errors++; $display("FAIL full_user%0d got=%h exp=%h", k, cap_user[k], eu); end
            checks++; if (cap_last[k] !== (k == 3)) begin errors++; $display("FAIL full_last%0d got=%b exp=%b", k, cap_last[k], k == 3); end
        end
    endtask

    task automatic test_trim;
        @(posedge clk); #1;
        fork
            push(2, 32'h0000_0FFF, 128'hC1, 1'b1);
            collect(3, 30, 100);
        join
        checks++; if (got !== 2) begin errors++; $display("FAIL trim_count got=%0d exp=2", got); end
        checks++; if (cap_data[0] !== mk_lane(2, 0)) begin errors++; $display("FAIL trim_data0 got=%h exp=%h", cap_data[0], mk_lane(2, 0)); end
        checks++; if (cap_strb[0] !== 8'hFF) begin errors++; $display("FAIL trim_strb0 got=%h exp=ff", cap_strb[0]); end
        checks++; if (cap_last[0] !== 1'b0) begin errors++; $display("FAIL trim_last0 got=%b exp=0", cap_last[0]); end
        checks++; if (cap_user[0] !== 128'hC1) begin errors++; $display("FAIL trim_user0 got=%h exp=c1", cap_user[0]); end
        checks++; if (cap_data[1] !== mk_lane(2, 1)) begin errors++; $display("FAIL trim_data1 got=%h exp=%h", cap_data[1], mk_lane(2, 1)); end
        checks++; if (cap_strb[1] !== 8'h0F) begin errors++; $display("FAIL trim_strb1 got=%h exp=0f", cap_strb[1]); end
        checks++; if (cap_last[1] !== 1'b1) begin errors++; $display("FAIL trim_last1 got=%b exp=1", cap_last[1]); end
        checks++; if (cap_user[1] !== '0) begin errors++; $display("FAIL trim_user1 got=%h exp=0", cap_user[1]); end
    endtask

    task automatic test_zero_strb;
        @(posedge clk); #1;
        fork
            push(3, '0, 128'hD2, 1'b1);
            collect(2, 30, 100);
        join
        checks++; if (got !== 1) begin errors++; $display("FAIL zero_count got=%0d exp=1", got); end
        checks++; if (cap_data[0] !== mk_lane(3, 0)) begin errors++; $display("FAIL zero_data got=%h exp=%h", cap_data[0], mk_lane(3, 0)); end
        checks++; if (cap_strb[0] !== 8'h00) begin errors++; $display("FAIL zero_strb got=%h exp=00", cap_strb[0]); end
        checks++; if (cap_last[0] !== 1'b1) begin errors++; $display("FAIL zero_last got=%b exp=1", cap_last[0]); end
        checks++; if (cap_user[0] !== 128'hD2) begin errors++; $display("FAIL zero_user got=%h exp=d2", cap_user[0]); end
    endtask

    task automatic test_back_to_back;
        logic [TU-1:0] eu;
        for (int pass = 0; pass < 2; pass++) begin
            int base;
            base = (pass == 0) ? 10 : 20;
            @(posedge clk); #1;
            fork
                begin
                    push(base,     '1, 128'h11, 1'b0);
                    push(base + 1, '1, 128'h99, 1'b0);
                    push(base + 2, '1, 128'h99, 1'b1);
                    push(base + 3, '1, 128'h22, 1'b1);
                end
                collect(16, 400, (pass == 0) ? 50 : 100);
            join
            checks++; if (got !== 16) begin errors++; $display("FAIL b2b%0d_count got=%0d exp=16", pass, got); end
            for (int i = 0; i < 16; i++) begin
                eu = (i == 0) ? 128'h11 : (i == 12) ? 128'h22 : '0;
                checks++; if (cap_data[i] !== mk_lane(base + i / 4, i % 4)) begin errors++; $display("FAIL b2b%0d_data%0d got=%h exp=%h", pass, i, cap_data[i], mk_lane(base + i / 4, i % 4)); end
                checks++; if (cap_last[i] !== (i == 11 || i == 15)) begin errors++; $display("FAIL b2b%0d_last%0d got=%b exp=%b", pass, i, cap_last[i], i == 11 || i == 15); end
                checks++; if (cap_user[i] !== eu) begin errors++; $display("FAIL b2b%0d_user%0d got=%h exp=%h", pass, i, cap_user[i], eu); end
                if (pass == 1 && i > 0) begin
                    checks++; if (cap_cyc[i] !== cap_cyc[0] + i) begin errors++; $display("FAIL b2b_bubble%0d got=%0d exp=%0d", i, cap_cyc[i], cap_cyc[0] + i); end
                end
            end
        end
        checks++; if (push_timeouts !== 0) begin errors++; $display("FAIL b2b_push_timeout got=%0d exp=0", push_timeouts); end
    endtask

    task automatic test_fifo_full;
        logic [TU-1:0] eu;
        @(posedge clk); #1;
        m_tready = 1'b0;
        for (int w = 0; w < 16; w++) push(30 + w, '1, (w == 0) ? 128'h55 : '0, 1'b0);
        checks++; if (push_timeouts !== 0) begin errors++; $display("FAIL full16_accept got=%0d timeouts exp=0", push_timeouts); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL fifo_full_tready%0d got=%b exp=0", c, s_tready); end
            checks++; if (m_tdata !== mk_lane(30, 0) || m_tvalid !== 1'b1) begin errors++; $display("FAIL fifo_full_hold%0d got=%h/%b exp=%h/1", c, m_tdata, m_tvalid, mk_lane(30, 0)); end
        end
        @(posedge clk); #1;
        fork
            push(46, '1, '0, 1'b1);
            collect(68, 400, 100);
        join
        checks++; if (got !== 68) begin errors++; $display("FAIL drain_count got=%0d exp=68", got); end
        for (int i = 0; i < 68; i++) begin
            eu = (i == 0) ? 128'h55 : '0;
            checks++; if (cap_data[i] !== mk_lane(30 + i / 4, i % 4)) begin errors++; $display("FAIL drain_data%0d got=%h exp=%h", i, cap_data[i], mk_lane(30 + i / 4, i % 4)); end
            checks++; if (cap_last[i] !== (i == 67)) begin errors++; $display("FAIL drain_last%0d got=%b exp=%b", i, cap_last[i], i == 67); end
            checks++; if (cap_user[i] !== eu) begin errors++; $display("FAIL drain_user%0d got=%h exp=%h", i, cap_user[i], eu); end
        end
        checks++; if (push_timeouts !== 0) begin errors++; $display("FAIL drain_push_timeout got=%0d exp=0", push_timeouts); end
    endtask

    task automatic test_mid_reset;
        bit found = 0;
        @(posedge clk); #1;
        push(50, '1, 128'h33, 1'b1);
        m_tready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (m_tvalid && m_tdata === mk_lane(50, 2)) found = 1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL midrst_reach_lane2 got=%b exp=1", found); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL midrst_tdata got=%h exp=0", m_tdata); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL midrst_s_tready got=%b exp=0", s_tready); end
        m_tready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fork
            push(51, '1, 128'h44, 1'b1);
            collect(5, 30, 100);
        join
        checks++; if (got !== 4) begin errors++; $display("FAIL midrst_count got=%0d exp=4", got); end
        checks++; if (cap_data[0] !== mk_lane(51, 0)) begin errors++; $display("FAIL midrst_data0 got=%h exp=%h", cap_data[0], mk_lane(51, 0)); end
        checks++; if (cap_user[0] !== 128'h44) begin errors++; $display("FAIL midrst_user0 got=%h exp=44", cap_user[0]); end
        checks++; if (cap_data[1] !== mk_lane(51, 1)) begin errors++; $display("FAIL midrst_data1 got=%h exp=%h", cap_data[1], mk_lane(51, 1)); end
        checks++; if (cap_last[3] !== 1'b1) begin errors++; $display("FAIL midrst_last3 got=%b exp=1", cap_last[3]); end
        checks++; if (push_timeouts !== 0) begin errors++; $display("FAIL midrst_push_timeout got=%0d exp=0", push_timeouts); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_trim();
        test_zero_strb();
        test_back_to_back();
        test_fifo_full();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
